fht_result_reader: RTL
======================

// Module: fht_result_reader
// PURPOSE
// Reads the finished transform out of the four FHT bank RAMs once the stage controller reports completion.
// Streams the N = 4*2^A_BIT points in natural order on a valid/ready interface, one sample per cycle at full rate.
// Consumer side of the bank RAMs: after the last stage, the controller writes them in direct order; this block reads them.
// PARAMETERS
// A_BIT       8   bank RAM address width; N = 4 << A_BIT points (1024 at default)
// D_BIT       16  sample width, two's complement
// RD_LAT      2   bank RAM read latency in cycles, from oRE/oADDR_RD to valid iRDATA_x
// FIFO_DEPTH  4   output FIFO entries; must be >= RD_LAT+2 for full throughput
// PORTS
// iCLK        in   1      clock
// iRESET      in   1      asynchronous reset, active-low
// iSTART      in   1      one-cycle pulse when the controller's ready output rises; ignored while oBUSY=1
// oRE         out  1      bank read enable, asserted for one cycle per issued read
// oADDR_RD    out  A_BIT  bank address, k >> 2 for point k
// iRDATA_0..3 in   D_BIT  bank 0..3 read data, valid RD_LAT cycles after oRE
// oDATA       out  D_BIT  output sample
// oVALID      out  1      oDATA valid
// iREADY      in   1      sink accepts; transfer when oVALID & iREADY
// oLAST       out  1      high with oVALID on point N-1
// oBUSY       out  1      readout in progress
// oDONE       out  1      one-cycle pulse after the last sample transfers
// BEHAVIOUR
// - Reset: oRE=0, oADDR_RD=0, oDATA=0, oVALID=0, oLAST=0, oBUSY=0, oDONE=0. FSM goes to IDLE, issue counter k=0, FIFO empty, in-flight=0.
// - Reset asserted mid-readout aborts the readout immediately. Data held in the FIFO is discarded. No oDONE is produced.
// - FSM IDLE -> READ on iSTART; k=0, oBUSY=1 from the following cycle.
// - READ: issues a read at point k when fifo_count + inflight < FIFO_DEPTH.
//   - Drives oRE=1 and oADDR_RD=k[A_BIT+1:2], and pipelines the bank select k[1:0] through RD_LAT stages.
//   - After the read of k=N-1 is issued, moves to DRAIN.
// - DRAIN: no issue. Moves to IDLE when the FIFO is empty and inflight=0, i.e. in the cycle the transfer of point N-1 completes.
//   - oDONE=1 for exactly one cycle; oBUSY=0 in the same cycle.
// - Returned data: iRDATA_[sel] is pushed into the FIFO RD_LAT cycles after issue. The credit rule guarantees the FIFO never overflows.
// - Output: oVALID = FIFO non-empty; oDATA/oLAST = FIFO head. The sink may hold iREADY=0 indefinitely; oDATA stays stable while oVALID & !iREADY.
// - Simultaneous push and pop: count unchanged. A pop from a single-entry FIFO concurrent with a push keeps oVALID=1.
// - Counters: k is A_BIT+2 bits wide and saturates at N-1, with no wrap. inflight is 0..RD_LAT.
// - Throughput: with iREADY=1 held, one sample per cycle. Latency from iSTART to first oVALID is RD_LAT+2 cycles.
// - iSTART while oBUSY=1: no effect.
// CONFIGURATION
// - Macro FHT_RD_SCALE_EN defined: samples are normalised by 1/N before the FIFO write.
//   - oDATA = (x + 2^(S-1)) >>> S, with S = A_BIT+2, arithmetic shift, round half up.
//   - The addition uses D_BIT+1 bits; the result is sign-extended back to D_BIT. No extra latency.
// - Macro not defined: the raw bank data passes unchanged.
// STRUCTURE
// - fht_pkg: N_BANK=4, BANK_SEL_BIT=2, FSM state enum {IDLE, READ, DRAIN}, helper function for N from A_BIT.
// - Sub-module fht_rd_fifo (synchronous FIFO, D_BIT+1 wide to carry the last flag, depth FIFO_DEPTH, count output).
// - Top level holds: FSM, issue counter, credit logic, bank-select delay line, bank mux, optional scaler.
// TESTING
// - Bank model with RD_LAT=2, where bank b at address a holds 4a+b. iSTART pulse with iREADY=1 -> oDATA = 0,1,...,1023 on consecutive cycles.
//   - oLAST only on 1023; oDONE one cycle after the last transfer.
// - iREADY toggled pseudo-randomly -> the same sequence with no loss or duplication; at most 4 outstanding reads+entries at any cycle.
// - iREADY=0 for 50 cycles after iSTART -> oRE stops after 4 issues; oDATA=0 held stable; resumes on iREADY=1.
// - iSTART pulsed again at sample 500 -> ignored; the sequence completes normally. iRESET pulled low at sample 300 -> all outputs 0 at once; a new iSTART restarts at 0.
// - FHT_RD_SCALE_EN with banks holding 0x7FFF / 0x8000 / 0x0200 / 0x01FF -> oDATA = 0x0020, 0xFFE0, 0x0001, 0x0000.

Source files
------------

// File: rtl/fht_pkg.sv
// Shared definitions for the FHT result readout path: bank geometry, FSM states, point count.
package fht_pkg;

  localparam int unsigned N_BANK       = 4;
  localparam int unsigned BANK_SEL_BIT = 2;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    DRAIN
  } fht_state_e;

  function automatic int unsigned fht_n(input int unsigned a_bit);
    return N_BANK << a_bit;
  endfunction

endpackage

// File: rtl/fht_rd_fifo.sv
// Synchronous output FIFO for the FHT readout; carries {last, sample} and exposes its fill count.
module fht_rd_fifo #(
  parameter int unsigned DW    = 17,
  parameter int unsigned DEPTH = 4
) (
  input  logic                           iCLK,
  input  logic                           iRESET,
  input  logic                           iPUSH,
  input  logic [DW-1:0]                  iWDATA,
  input  logic                           iPOP,
  output logic [DW-1:0]                  oRDATA,
  output logic                           oEMPTY,
  output logic [$clog2(DEPTH+1)-1:0]     oCOUNT
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH+1);

  logic [DW-1:0] r_mem [DEPTH];
  logic [PW-1:0] r_wp;
  logic [PW-1:0] r_rp;
  logic [CW-1:0] r_cnt;
  logic          w_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH-1)) ? '0 : p + PW'(1);
  endfunction

  assign w_pop  = iPOP && (r_cnt != '0);
  assign oEMPTY = (r_cnt == '0);
  assign oCOUNT = r_cnt;
  assign oRDATA = r_mem[r_rp];

  always_ff @(posedge iCLK or negedge iRESET) begin
    if (!iRESET) begin
      for (int unsigned i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (iPUSH) begin
        r_mem[r_wp] <= iWDATA;
        r_wp        <= ptr_inc(r_wp);
      end
      if (w_pop) r_rp <= ptr_inc(r_rp);
      case ({iPUSH, w_pop})
        2'b10:   r_cnt <= r_cnt + CW'(1);
        2'b01:   r_cnt <= r_cnt - CW'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

endmodule

// File: rtl/fht_result_reader.sv
// Streams the finished FHT out of the four bank RAMs in natural order with credit-based flow control.
// Optional macro FHT_RD_SCALE_EN normalises each sample by 1/N (round half up) before buffering.
module fht_result_reader
  import fht_pkg::*;
#(
  parameter int unsigned A_BIT      = 8,
  parameter int unsigned D_BIT      = 16,
  parameter int unsigned RD_LAT     = 2,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic             iCLK,
  input  logic             iRESET,
  input  logic             iSTART,
  output logic             oRE,
  output logic [A_BIT-1:0] oADDR_RD,
  input  logic [D_BIT-1:0] iRDATA_0,
  input  logic [D_BIT-1:0] iRDATA_1,
  input  logic [D_BIT-1:0] iRDATA_2,
  input  logic [D_BIT-1:0] iRDATA_3,
  output logic [D_BIT-1:0] oDATA,
  output logic             oVALID,
  input  logic             iREADY,
  output logic             oLAST,
  output logic             oBUSY,
  output logic             oDONE
);

  localparam int unsigned N  = fht_n(A_BIT);
  localparam int unsigned KW = A_BIT + BANK_SEL_BIT;
  localparam int unsigned CW = $clog2(FIFO_DEPTH+1);
  localparam int unsigned IW = $clog2(RD_LAT+1);

  fht_state_e r_state, w_state_nxt;
  logic [KW-1:0]           r_k;
  logic [IW-1:0]           r_inflight;
  logic [RD_LAT-1:0]       r_vld;
  logic [RD_LAT-1:0]       r_last;
  logic [BANK_SEL_BIT-1:0] r_sel [RD_LAT];
  logic                    r_done;
  logic                    w_done_nxt;
  logic                    w_issue;
  logic                    w_push;
  logic                    w_pop;
  logic                    w_k_end;
  logic [D_BIT-1:0]        w_raw;
  logic [D_BIT-1:0]        w_samp;
  logic [D_BIT:0]          w_fifo_rdata;
  logic                    w_fifo_empty;
  logic [CW-1:0]           w_fifo_count;

  // Credit counts both buffered entries and reads still in the bank pipeline.
  assign w_k_end  = (r_k == KW'(N-1));
  assign w_issue  = (r_state == READ) &&
                    ((32'(w_fifo_count) + 32'(r_inflight)) < 32'(FIFO_DEPTH));
  assign w_push   = r_vld[RD_LAT-1];
  assign w_pop    = oVALID && iREADY;

  assign oRE      = w_issue;
  assign oADDR_RD = r_k[KW-1:BANK_SEL_BIT];
  assign oVALID   = !w_fifo_empty;
  assign oDATA    = w_fifo_rdata[D_BIT-1:0];
  assign oLAST    = oVALID && w_fifo_rdata[D_BIT];
  assign oBUSY    = (r_state != IDLE);
  assign oDONE    = r_done;

  always_comb begin
    w_state_nxt = r_state;
    w_done_nxt  = 1'b0;
    case (r_state)
      IDLE:  if (iSTART) w_state_nxt = READ;
      READ:  if (w_issue && w_k_end) w_state_nxt = DRAIN;
      DRAIN: if (w_pop && w_fifo_rdata[D_BIT]) begin
               w_state_nxt = IDLE;
               w_done_nxt  = 1'b1;
             end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge iCLK or negedge iRESET) begin
    if (!iRESET) begin
      r_state    <= IDLE;
      r_done     <= 1'b0;
      r_k        <= '0;
      r_inflight <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_done  <= w_done_nxt;
      if (r_state == IDLE && iSTART) r_k <= '0;
      else if (w_issue && !w_k_end)  r_k <= r_k + KW'(1);
      case ({w_issue, w_push})
        2'b10:   r_inflight <= r_inflight + IW'(1);
        2'b01:   r_inflight <= r_inflight - IW'(1);
        default: r_inflight <= r_inflight;
      endcase
    end
  end

  always_ff @(posedge iCLK or negedge iRESET) begin
    if (!iRESET) begin
      r_vld  <= '0;
      r_last <= '0;
      for (int unsigned i = 0; i < RD_LAT; i++) r_sel[i] <= '0;
    end else begin
      r_vld[0]  <= w_issue;
      r_last[0] <= w_issue && w_k_end;
      r_sel[0]  <= r_k[BANK_SEL_BIT-1:0];
      for (int unsigned i = 1; i < RD_LAT; i++) begin
        r_vld[i]  <= r_vld[i-1];
        r_last[i] <= r_last[i-1];
        r_sel[i]  <= r_sel[i-1];
      end
    end
  end

  always_comb begin
    w_raw = iRDATA_0;
    case (r_sel[RD_LAT-1])
      2'd0:    w_raw = iRDATA_0;
      2'd1:    w_raw = iRDATA_1;
      2'd2:    w_raw = iRDATA_2;
      default: w_raw = iRDATA_3;
    endcase
  end

`ifdef FHT_RD_SCALE_EN
  localparam logic [D_BIT:0] RND = (D_BIT+1)'(1) << (KW-1);
  logic [D_BIT:0]        w_sum;
  logic signed [D_BIT:0] w_shift;
  assign w_sum   = {w_raw[D_BIT-1], w_raw} + RND;
  assign w_shift = $signed(w_sum) >>> KW;
  assign w_samp  = D_BIT'(w_shift);
`else
  assign w_samp  = w_raw;
`endif

  fht_rd_fifo #(
    .DW    (D_BIT+1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .iCLK   (iCLK),
    .iRESET (iRESET),
    .iPUSH  (w_push),
    .iWDATA ({r_last[RD_LAT-1], w_samp}),
    .iPOP   (w_pop),
    .oRDATA (w_fifo_rdata),
    .oEMPTY (w_fifo_empty),
    .oCOUNT (w_fifo_count)
  );

endmodule
